// File: rtl/ones_det_pkg.sv
// rtl/ones_det_pkg.sv - shared types, defaults and sizing helper for the ones-detector scheduler
package ones_det_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_e;

    // Width needed to hold 0..data_w/4 four-ones events
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w / 4 + 1);
    endfunction

endpackage

// File: rtl/ones_mod4_fsm.sv
// rtl/ones_mod4_fsm.sv - Moore ones-counter mod 4 with four-ones event flag
module ones_mod4_fsm
    import ones_det_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] state,
    output logic       evt
);

    det_state_e state_q;
    det_state_e state_d;

    // Advance on each accepted 1, hold on 0; clear wins over stepping
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S0;
        end else if (en && bit_in) begin
            case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = S3;
                S3:      state_d = S0;
                default: state_d = S0;
            endcase
        end
    end

    // Detector state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    // A fourth one lands while already in S3
    assign evt   = en & bit_in & ~clr & (state_q == S3);

endmodule

// File: rtl/ones_det_scheduler.sv
// rtl/ones_det_scheduler.sv - round-robin scheduler sharing one serial ones detector among requesters
module ones_det_scheduler
    import ones_det_pkg::*;
#(
    parameter  int N_REQ  = DEF_N_REQ,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int CNT_W  = cnt_w(DATA_W),
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      ser_bit,
    output logic                      done,
    output logic [IDX_W-1:0]          done_id,
    output logic [CNT_W-1:0]          det_count,
    output logic [1:0]                ones_mod4
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  det_count_q, det_count_d;
    logic [1:0]        mod_q, mod_d;
    logic [N_REQ-1:0]  grant_q, grant_d;

    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;
    int                arb_j;

    logic              det_clr;
    logic              det_en;
    logic              det_bit;
    logic [1:0]        det_state;
    logic              det_evt;

    // Rotating priority search: start at ptr, wrap upward, first set request wins
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_j = int'(ptr_q) + i;
            if (arb_j >= N_REQ) begin
                arb_j = arb_j - N_REQ;
            end
            if (!arb_found && req[arb_j[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_j[IDX_W-1:0];
            end
        end
    end

    assign det_clr = (state_q == ST_IDLE) && arb_found;
    assign det_en  = (state_q == ST_SHIFT);
    assign det_bit = shift_q[0];

    ones_mod4_fsm u_det (
        .clk    (clk),
        .reset  (reset),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (det_bit),
        .state  (det_state),
        .evt    (det_evt)
    );

    // Scheduler next-state: capture in IDLE, stream bits in SHIFT, report in DONE
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        det_count_d = det_count_q;
        mod_d       = mod_q;
        grant_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    shift_d   = data_in[arb_idx*DATA_W +: DATA_W];
                    bit_cnt_d = '0;
                    acc_d     = '0;
                    grant_d   = N_REQ'(1) << arb_idx;
                    winner_d  = arb_idx;
                    ptr_d     = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                acc_d     = acc_q + CNT_W'(det_evt);
                if (bit_cnt_q == LAST_BIT) begin
                    // Include the final bit's contribution in the reported results
                    det_count_d = acc_q + CNT_W'(det_evt);
                    mod_d       = det_state + {1'b0, det_bit};
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            det_count_q <= '0;
            mod_q       <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            det_count_q <= det_count_d;
            mod_q       <= mod_d;
            grant_q     <= grant_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign ser_bit   = (state_q == ST_SHIFT) & shift_q[0];
    assign done      = (state_q == ST_DONE);
    assign done_id   = done ? winner_q : '0;
    assign det_count = det_count_q;
    assign ones_mod4 = mod_q;

endmodule
